// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, samples synchronized
// rows at the end of each column dwell and holds on the first pressed key found.
module keypad_scanner #(
  parameter int SCAN_DIV = 48000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_pressed,
  output logic [3:0] key_code,
  output logic       dbg_hold_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic {
    S_SCAN = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    rows_m_q;
  logic [3:0]    rows_s_q;
  logic [1:0]    col_q, col_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    held_row_q, held_row_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_pressed_q, key_pressed_d;

  logic          sample_pt;
  logic          any_low;
  logic          released;
  logic [1:0]    low_row;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      4'b11_11: k = 4'hD;
      default:  k = 4'h0;
    endcase
    return k;
  endfunction

  assign sample_pt = (state_q == S_SCAN) && (cnt_q == CNT_LAST);
  assign any_low   = (rows_s_q != 4'hF);
  assign released  = rows_s_q[held_row_q];

  // Lowest-index low row wins when several keys share the driven column.
  always_comb begin
    low_row = 2'd3;
    if (!rows_s_q[0])      low_row = 2'd0;
    else if (!rows_s_q[1]) low_row = 2'd1;
    else if (!rows_s_q[2]) low_row = 2'd2;
  end

  // State register, row synchronizer and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_SCAN;
      rows_m_q      <= 4'hF;
      rows_s_q      <= 4'hF;
      col_q         <= 2'd0;
      cnt_q         <= '0;
      held_row_q    <= 2'd0;
      key_code_q    <= 4'h0;
      key_pressed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rows_m_q      <= rows;
      rows_s_q      <= rows_m_q;
      col_q         <= col_d;
      cnt_q         <= cnt_d;
      held_row_q    <= held_row_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SCAN:  if (sample_pt && any_low) state_d = S_HOLD;
      S_HOLD:  if (released)             state_d = S_SCAN;
      default:                           state_d = S_SCAN;
    endcase
  end

  // Column stays frozen in HOLD; it advances only on an empty sample or a release.
  always_comb begin
    col_d         = col_q;
    cnt_d         = cnt_q;
    held_row_d    = held_row_q;
    key_code_d    = key_code_q;
    key_pressed_d = key_pressed_q;
    case (state_q)
      S_SCAN: begin
        if (sample_pt) begin
          cnt_d = '0;
          if (any_low) begin
            held_row_d    = low_row;
            key_code_d    = key_map(low_row, col_q);
            key_pressed_d = 1'b1;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        cnt_d = '0;
        if (released) begin
          key_pressed_d = 1'b0;
          col_d         = col_q + 2'd1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_comb begin
    cols        = ~(4'b0001 << col_q);
    key_pressed = key_pressed_q;
    key_code    = key_code_q;
    dbg_hold_o  = (state_q == S_HOLD);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV = 4 and a keypad model that
// pulls a row low when a held key sits on the currently driven column.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       key_pressed;
  logic [3:0] key_code;
  logic       dbg_hold_o;

  logic [15:0] keys;
  int checks;
  int errors;

  keypad_scanner #(.SCAN_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rows        (rows),
    .cols        (cols),
    .key_pressed (key_pressed),
    .key_code    (key_code),
    .dbg_hold_o  (dbg_hold_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Held key at (r, c) is bit r*4+c of k.
  function automatic logic [3:0] pad(input logic [3:0] c, input logic [15:0] k);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (k[ri*4+ci] && !c[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  task automatic apply();
    rows = pad(cols, keys);
  endtask

  task automatic cycle();
    @(negedge clk);
    apply();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cols(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (cols !== target && n < 64) begin
      cycle();
      n++;
    end
    chk(tag, {4'h0, cols}, {4'h0, target});
  endtask

  initial begin
    logic [3:0] exp_cols;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    rows   = 4'hF;
    keys   = 16'h0;

    repeat (3) cycle();
    chk("reset_cols", {4'h0, cols}, 8'h0E);
    chk("reset_kp", {7'h0, key_pressed}, 8'h00);
    chk("reset_code", {4'h0, key_code}, 8'h00);
    chk("reset_state", {7'h0, dbg_hold_o}, 8'h00);
    reset = 1'b0;

    // Idle sweep: each column driven for exactly 4 cycles.
    for (int i = 0; i < 40; i++) begin
      if (i > 0) cycle();
      exp_cols = ~(4'b0001 << ((i / 4) % 4));
      chk("idle_cols", {4'h0, cols}, {4'h0, exp_cols});
      chk("idle_kp", {7'h0, key_pressed}, 8'h00);
      chk("idle_code", {4'h0, key_code}, 8'h00);
    end

    // Key 6 at r1 c2.
    keys = 16'h0040;
    apply();
    wait_cols(4'b1011, "k6_reach_col2");
    repeat (3) begin
      cycle();
      chk("k6_before_sample", {7'h0, key_pressed}, 8'h00);
    end
    cycle();
    chk("k6_kp", {7'h0, key_pressed}, 8'h01);
    chk("k6_code", {4'h0, key_code}, 8'h06);
    chk("k6_hold_state", {7'h0, dbg_hold_o}, 8'h01);
    for (int j = 0; j < 6; j++) begin
      cycle();
      chk("k6_frozen_cols", {4'h0, cols}, 8'h0B);
      chk("k6_held_kp", {7'h0, key_pressed}, 8'h01);
    end

    // Release 6: key_pressed drops 3 cycles after the row rises.
    keys = 16'h0;
    apply();
    cycle();
    chk("k6_rel_1", {7'h0, key_pressed}, 8'h01);
    cycle();
    chk("k6_rel_2", {7'h0, key_pressed}, 8'h01);
    cycle();
    chk("k6_rel_kp", {7'h0, key_pressed}, 8'h00);
    chk("k6_rel_cols", {4'h0, cols}, 8'h07);
    chk("k6_rel_code", {4'h0, key_code}, 8'h06);

    // Keys 0 (r3 c1) and 5 (r1 c1) together.
    keys = 16'h2020;
    apply();
    wait_cols(4'b1101, "k05_reach_col1");
    repeat (3) cycle();
    chk("k05_before_sample", {7'h0, key_pressed}, 8'h00);
    cycle();
    chk("k05_kp", {7'h0, key_pressed}, 8'h01);
    chk("k05_code", {4'h0, key_code}, 8'h05);
    keys = 16'h0020;
    apply();
    for (int j = 0; j < 6; j++) begin
      cycle();
      chk("k0_released_kp", {7'h0, key_pressed}, 8'h01);
      chk("k0_released_cols", {4'h0, cols}, 8'h0D);
    end
    keys = 16'h0;
    apply();
    repeat (2) cycle();
    chk("k5_rel_2", {7'h0, key_pressed}, 8'h01);
    cycle();
    chk("k5_rel_kp", {7'h0, key_pressed}, 8'h00);
    chk("k5_rel_cols", {4'h0, cols}, 8'h0B);
    chk("k5_rel_code", {4'h0, key_code}, 8'h05);

    // One-cycle glitch on rows[0] at the start of the col-0 dwell.
    wait_cols(4'b1110, "glitch_reach_col0");
    rows = 4'b1110;
    for (int j = 0; j < 8; j++) begin
      cycle();
      chk("glitch_kp", {7'h0, key_pressed}, 8'h00);
    end
    chk("glitch_cols", {4'h0, cols}, 8'h0B);
    chk("glitch_code", {4'h0, key_code}, 8'h05);

    // Key D (r3 c3), then reset while holding.
    keys = 16'h8000;
    apply();
    wait_cols(4'b0111, "kd_reach_col3");
    repeat (3) cycle();
    chk("kd_before_sample", {7'h0, key_pressed}, 8'h00);
    cycle();
    chk("kd_kp", {7'h0, key_pressed}, 8'h01);
    chk("kd_code", {4'h0, key_code}, 8'h0D);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("kd_rst_cols", {4'h0, cols}, 8'h0E);
    chk("kd_rst_kp", {7'h0, key_pressed}, 8'h00);
    chk("kd_rst_code", {4'h0, key_code}, 8'h00);
    chk("kd_rst_state", {7'h0, dbg_hold_o}, 8'h00);
    for (int i = 1; i <= 15; i++) begin
      cycle();
      chk("kd_rescan_kp", {7'h0, key_pressed}, 8'h00);
    end
    chk("kd_rescan_cols", {4'h0, cols}, 8'h07);
    cycle();
    chk("kd_redetect_kp", {7'h0, key_pressed}, 8'h01);
    chk("kd_redetect_code", {4'h0, key_code}, 8'h0D);
    chk("kd_redetect_cols", {4'h0, cols}, 8'h07);

    keys = 16'h0;
    apply();
    repeat (3) cycle();
    chk("kd_rel_kp", {7'h0, key_pressed}, 8'h00);
    chk("kd_rel_cols", {4'h0, cols}, 8'h0E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
